// File: rtl/cga_vram_arbiter.sv
// Arbitrates the single 8-bit video RAM port between CGA display fetch and CPU ISA cycles.
// Display fetch always owns the port; CPU cycles wait for a free sequencer slot.
module cga_vram_arbiter #(
    parameter int RAM_LATENCY  = 1,
    parameter int USE_BUS_WAIT = 1,
    parameter int TIMEOUT      = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        disp_req_i,
    input  logic [18:0] disp_addr_i,
    output logic [7:0]  disp_data_o,
    input  logic        isa_op_enable_i,
    input  logic        mem_cs_i,
    input  logic [14:0] bus_a_i,
    input  logic        bus_memr_l_i,
    input  logic        bus_memw_l_i,
    input  logic [7:0]  bus_d_i,
    output logic [7:0]  cpu_rdata_o,
    output logic        bus_rdy_o,
    output logic [18:0] ram_addr_o,
    output logic        ram_we_o,
    output logic [7:0]  ram_wdata_o,
    input  logic [7:0]  ram_rdata_i,
    output logic        timeout_err_o
);

    typedef enum logic [1:0] {IDLE, WAIT_SLOT, ACCESS, DONE} state_t;

    localparam logic [1:0] LatCnt     = 2'(RAM_LATENCY);
    localparam logic [4:0] TimeoutCnt = 5'(TIMEOUT);
    localparam int         LatIdx     = RAM_LATENCY - 1;

    state_t                 state_q, state_d;
    logic [1:0]             memrSync_q, memwSync_q;
    logic                   memrPrev_q, memwPrev_q;
    logic [14:0]            addr_q, addr_d;
    logic [7:0]             data_q, data_d;
    logic                   wr_q, wr_d;
    logic [4:0]             waitCnt_q, waitCnt_d;
    logic [1:0]             accCnt_q, accCnt_d;
    logic [7:0]             cpuRdata_q, cpuRdata_d;
    logic                   timeoutErr_q, timeoutErr_d;
    logic [7:0]             dispData_q, dispData_d;
    logic [RAM_LATENCY-1:0] dispPipe_q, dispPipe_d;

    logic memrS, memwS, reqFall, grant, strobeHeld;

    assign memrS      = memrSync_q[1];
    assign memwS      = memwSync_q[1];
    assign reqFall    = mem_cs_i && ((memrPrev_q && !memrS) || (memwPrev_q && !memwS));
    assign grant      = !disp_req_i && (isa_op_enable_i || (waitCnt_q == TimeoutCnt));
    assign strobeHeld = wr_q ? !memwS : !memrS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            memrSync_q   <= 2'b11;
            memwSync_q   <= 2'b11;
            memrPrev_q   <= 1'b1;
            memwPrev_q   <= 1'b1;
            addr_q       <= '0;
            data_q       <= '0;
            wr_q         <= 1'b0;
            waitCnt_q    <= '0;
            accCnt_q     <= '0;
            cpuRdata_q   <= '0;
            timeoutErr_q <= 1'b0;
            dispData_q   <= '0;
            dispPipe_q   <= '0;
        end else begin
            state_q      <= state_d;
            memrSync_q   <= {memrSync_q[0], bus_memr_l_i};
            memwSync_q   <= {memwSync_q[0], bus_memw_l_i};
            memrPrev_q   <= memrS;
            memwPrev_q   <= memwS;
            addr_q       <= addr_d;
            data_q       <= data_d;
            wr_q         <= wr_d;
            waitCnt_q    <= waitCnt_d;
            accCnt_q     <= accCnt_d;
            cpuRdata_q   <= cpuRdata_d;
            timeoutErr_q <= timeoutErr_d;
            dispData_q   <= dispData_d;
            dispPipe_q   <= dispPipe_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        wr_d         = wr_q;
        waitCnt_d    = waitCnt_q;
        accCnt_d     = accCnt_q;
        cpuRdata_d   = cpuRdata_q;
        timeoutErr_d = timeoutErr_q;
        dispData_d   = dispData_q;

        dispPipe_d[0] = disp_req_i;
        for (int i = 1; i < RAM_LATENCY; i++) begin
            dispPipe_d[i] = dispPipe_q[i-1];
        end
        if (dispPipe_q[LatIdx]) begin
            dispData_d = ram_rdata_i;
        end

        case (state_q)
            IDLE: begin
                if (reqFall) begin
                    addr_d    = bus_a_i;
                    data_d    = bus_d_i;
                    wr_d      = !memwS;
                    waitCnt_d = '0;
                    state_d   = WAIT_SLOT;
                end
            end
            WAIT_SLOT: begin
                // A released read is dropped; a released write stays posted.
                if (!strobeHeld && !wr_q) begin
                    state_d = IDLE;
                end else if (grant) begin
                    accCnt_d = '0;
                    state_d  = ACCESS;
                    if (!isa_op_enable_i) begin
                        timeoutErr_d = 1'b1;
                    end
                end else if (waitCnt_q != TimeoutCnt) begin
                    waitCnt_d = waitCnt_q + 5'd1;
                end
            end
            ACCESS: begin
                if (disp_req_i) begin
                    state_d = WAIT_SLOT;
                end else if (!strobeHeld && !wr_q) begin
                    state_d = IDLE;
                end else if (accCnt_q == LatCnt) begin
                    if (!wr_q) begin
                        cpuRdata_d = ram_rdata_i;
                    end
                    state_d = (wr_q && memwS) ? IDLE : DONE;
                end else begin
                    accCnt_d = accCnt_q + 2'd1;
                end
            end
            DONE: begin
                if (memrS && memwS) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Display fetch overrides the CPU on the RAM port in the same clock.
    assign ram_addr_o    = disp_req_i ? disp_addr_i :
                           (state_q == ACCESS) ? {4'h0, addr_q} : '0;
    assign ram_we_o      = !disp_req_i && (state_q == ACCESS) && wr_q;
    assign ram_wdata_o   = data_q;
    assign bus_rdy_o     = (USE_BUS_WAIT == 0) || (state_q == IDLE) || (state_q == DONE);
    assign cpu_rdata_o   = cpuRdata_q;
    assign disp_data_o   = dispData_q;
    assign timeout_err_o = timeoutErr_q;

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Scoreboard bench for cga_vram_arbiter: directed CPU/display vectors against an SRAM model,
// with a negedge monitor popping expected display and CPU read bytes.
module tb_cga_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        disp_req_i;
    logic [18:0] disp_addr_i;
    logic [7:0]  disp_data_o;
    logic        isa_op_enable_i;
    logic        mem_cs_i;
    logic [14:0] bus_a_i;
    logic        bus_memr_l_i;
    logic        bus_memw_l_i;
    logic [7:0]  bus_d_i;
    logic [7:0]  cpu_rdata_o;
    logic        bus_rdy_o;
    logic [18:0] ram_addr_o;
    logic        ram_we_o;
    logic [7:0]  ram_wdata_o;
    logic [7:0]  ram_rdata_i;
    logic        timeout_err_o;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0]  dispQ[$];
    logic [7:0]  cpuQ[$];
    logic [14:0] expWrAddr = '0;
    logic [18:0] watchAddr = 19'h7FFFF;
    int          watchHits = 0;
    logic        prevRdy   = 1'b1;
    logic        dv1 = 1'b0, dv2 = 1'b0;

    logic [7:0] wmem [int];
    logic [7:0] rdPipe = '0;

    cga_vram_arbiter #(.RAM_LATENCY(1), .USE_BUS_WAIT(1), .TIMEOUT(31)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_req_i(disp_req_i), .disp_addr_i(disp_addr_i), .disp_data_o(disp_data_o),
        .isa_op_enable_i(isa_op_enable_i), .mem_cs_i(mem_cs_i), .bus_a_i(bus_a_i),
        .bus_memr_l_i(bus_memr_l_i), .bus_memw_l_i(bus_memw_l_i), .bus_d_i(bus_d_i),
        .cpu_rdata_o(cpu_rdata_o), .bus_rdy_o(bus_rdy_o),
        .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_wdata_o(ram_wdata_o),
        .ram_rdata_i(ram_rdata_i), .timeout_err_o(timeout_err_o)
    );

    always #5 clk = ~clk;

    // Unwritten locations hold a fixed pattern so expected bytes are computable.
    function automatic logic [7:0] patt(input logic [18:0] a);
        return (a[7:0] ^ a[15:8]) + 8'h38 + {5'b0, a[18:16]};
    endfunction

    function automatic logic [7:0] memRead(input logic [18:0] a);
        if (wmem.exists(int'(a))) return wmem[int'(a)];
        return patt(a);
    endfunction

    always @(posedge clk) begin
        rdPipe <= memRead(ram_addr_o);
        if (ram_we_o) wmem[int'(ram_addr_o)] = ram_wdata_o;
    end
    assign ram_rdata_i = rdPipe;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        dv1 <= disp_req_i;
        dv2 <= dv1;
    end

    // Monitor: pops expected bytes whenever the DUT presents display or CPU read data.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst_n) begin
            if (dv2) begin
                if (dispQ.size() == 0) checkOutput("disp unexpected", 1, 0);
                else begin
                    e = dispQ.pop_front();
                    checkOutput("disp_data", {24'h0, disp_data_o}, {24'h0, e});
                end
            end
            if (ram_we_o) begin
                checkOutput("we with disp_req", {31'h0, disp_req_i}, 0);
                checkOutput("write addr", {13'h0, ram_addr_o}, {17'h0, expWrAddr});
            end
            if (ram_addr_o == watchAddr) watchHits++;
            if (bus_rdy_o && !prevRdy && !bus_memr_l_i && bus_memw_l_i) begin
                if (cpuQ.size() == 0) checkOutput("cpu read unexpected", 1, 0);
                else begin
                    e = cpuQ.pop_front();
                    checkOutput("cpu_rdata", {24'h0, cpu_rdata_o}, {24'h0, e});
                end
            end
        end
        prevRdy = bus_rdy_o;
    end

    task automatic waitRdy(input int budget, output int n, output bit sawLow);
        sawLow = 1'b0;
        n = budget + 1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            if (!bus_rdy_o) sawLow = 1'b1;
            else if (sawLow) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic cpuRead(input logic [14:0] a, input logic [7:0] exp, input int expLat);
        int n;
        bit s;
        @(posedge clk); #1;
        bus_a_i = a;
        mem_cs_i = 1'b1;
        bus_memr_l_i = 1'b0;
        cpuQ.push_back(exp);
        waitRdy(80, n, s);
        checkOutput("read rdy went low", {31'h0, s}, 1);
        checkOutput("read latency", n, expLat);
        @(posedge clk); #1;
        bus_memr_l_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic cpuWrite(input logic [14:0] a, input logic [7:0] d, input int expLat);
        int n;
        bit s;
        @(posedge clk); #1;
        bus_a_i = a;
        bus_d_i = d;
        expWrAddr = a;
        mem_cs_i = 1'b1;
        bus_memw_l_i = 1'b0;
        waitRdy(80, n, s);
        checkOutput("write rdy went low", {31'h0, s}, 1);
        if (expLat >= 0) checkOutput("write latency", n, expLat);
        @(posedge clk); #1;
        bus_memw_l_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic applyStimulus();
        bit rdyLow;
        // Reset values
        #3;
        checkOutput("reset bus_rdy", {31'h0, bus_rdy_o}, 1);
        checkOutput("reset ram_we", {31'h0, ram_we_o}, 0);
        checkOutput("reset ram_addr", {13'h0, ram_addr_o}, 0);
        checkOutput("reset disp_data", {24'h0, disp_data_o}, 0);
        checkOutput("reset cpu_rdata", {24'h0, cpu_rdata_o}, 0);
        checkOutput("reset timeout_err", {31'h0, timeout_err_o}, 0);
        checkOutput("reset ram_wdata", {24'h0, ram_wdata_o}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: ideal read of 0x0123 holding 0x5A
        isa_op_enable_i = 1'b1;
        cpuRead(15'h0123, 8'h5A, 6);

        // 2: write with display toggling every clock for 20 clocks
        fork
            cpuWrite(15'h7FFF, 8'hC3, -1);
            begin
                @(posedge clk); #1;
                for (int i = 0; i < 20; i++) begin
                    disp_req_i = (i % 2 == 0);
                    disp_addr_i = 19'h40000 + 19'(i);
                    if (disp_req_i) dispQ.push_back(patt(disp_addr_i));
                    @(posedge clk); #1;
                end
                disp_req_i = 1'b0;
            end
        join
        checkOutput("ram 7FFF", {24'h0, memRead(19'h07FFF)}, 32'hC3);

        // 3: display steals the port in the second access clock
        fork
            cpuWrite(15'h0456, 8'h96, 9);
            begin
                @(posedge clk); #1;
                repeat (4) @(posedge clk);
                #1;
                checkOutput("access we before steal", {31'h0, ram_we_o}, 1);
                @(posedge clk); #1;
                disp_req_i = 1'b1;
                disp_addr_i = 19'h41234;
                dispQ.push_back(8'h62);
                #1;
                checkOutput("we dropped on steal", {31'h0, ram_we_o}, 0);
                checkOutput("disp addr on steal", {13'h0, ram_addr_o}, 32'h41234);
                @(posedge clk); #1;
                disp_req_i = 1'b0;
            end
        join
        checkOutput("ram 0456", {24'h0, memRead(19'h00456)}, 32'h96);
        checkOutput("no timeout yet", {31'h0, timeout_err_o}, 0);

        // 4: no slots -> forced grant at counter 31
        isa_op_enable_i = 1'b0;
        cpuRead(15'h0200, 8'h3A, 37);
        checkOutput("timeout_err set", {31'h0, timeout_err_o}, 1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("timeout_err sticky", {31'h0, timeout_err_o}, 1);
        applyReset();
        #1;
        checkOutput("timeout_err cleared", {31'h0, timeout_err_o}, 0);

        // 5a: write strobe released while waiting for a slot
        @(posedge clk); #1;
        bus_a_i = 15'h0300;
        bus_d_i = 8'h77;
        expWrAddr = 15'h0300;
        bus_memw_l_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("posted wr rdy low", {31'h0, bus_rdy_o}, 0);
        bus_memw_l_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        isa_op_enable_i = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("posted write landed", {24'h0, memRead(19'h00300)}, 32'h77);
        checkOutput("posted wr rdy", {31'h0, bus_rdy_o}, 1);
        cpuRead(15'h0123, 8'h5A, 6);

        // 5b: read strobe released while waiting for a slot
        isa_op_enable_i = 1'b0;
        watchAddr = 19'h00310;
        watchHits = 0;
        @(posedge clk); #1;
        bus_a_i = 15'h0310;
        bus_memr_l_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("aborted rd rdy low", {31'h0, bus_rdy_o}, 0);
        bus_memr_l_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("aborted rd rdy", {31'h0, bus_rdy_o}, 1);
        isa_op_enable_i = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("aborted rd ram hits", watchHits, 0);
        checkOutput("aborted rd cpu_rdata", {24'h0, cpu_rdata_o}, 32'h5A);

        // mem_cs low: strobe ignored
        mem_cs_i = 1'b0;
        bus_memr_l_i = 1'b0;
        rdyLow = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (!bus_rdy_o) rdyLow = 1'b1;
        end
        checkOutput("mem_cs low rdy", {31'h0, rdyLow}, 0);
        bus_memr_l_i = 1'b1;
        mem_cs_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // 6: async reset during a write access
        @(posedge clk); #1;
        bus_a_i = 15'h0400;
        bus_d_i = 8'hA5;
        expWrAddr = 15'h0400;
        bus_memw_l_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("wr access we", {31'h0, ram_we_o}, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async rst we", {31'h0, ram_we_o}, 0);
        checkOutput("async rst rdy", {31'h0, bus_rdy_o}, 1);
        bus_memw_l_i = 1'b1;
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("lost write", {24'h0, memRead(19'h00400)}, 32'h3C);
        cpuRead(15'h0123, 8'h5A, 6);
    endtask

    initial begin
        rst_n = 1'b0;
        disp_req_i = 1'b0;
        disp_addr_i = '0;
        isa_op_enable_i = 1'b0;
        mem_cs_i = 1'b1;
        bus_a_i = '0;
        bus_memr_l_i = 1'b1;
        bus_memw_l_i = 1'b1;
        bus_d_i = '0;

        applyStimulus();

        repeat (5) @(posedge clk);
        #1;
        checkOutput("disp queue drained", dispQ.size(), 0);
        checkOutput("cpu queue drained", cpuQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
